fpu_vec_shuf_pipe: RTL and testbench
====================================

Name: fpu_vec_shuf_pipe

Overview:
- Parametrised, pipelined lane-shuffle unit for the FPU vector path.
- Generalises the fixed 4:1 per-lane select to NLANES lanes of LANEW bits each.
- Adds per-lane index, broadcast, reverse and zero-mask modes, plus valid/ready flow control.
- Sits between the vector register read stage and the FPU vector ALU. Produces one permuted vector per accepted input, two cycles later when unstalled.

Parameters:
- NLANES, 4: lane count; power of two, 2..16.
- LANEW, 32: bits per lane; 16, 32 or 64.
- IDXW, $clog2(NLANES): lane index width (derived, not overridden).

Ports:
- clock  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-low reset (low = reset on clock edge).
- inValid  in  1: input vector valid.
- inReady  out  1: unit can accept this cycle.
- inVec  in  NLANES*LANEW: source lanes; lane k at [k*LANEW +: LANEW].
- inIdx  in  NLANES*IDXW: per-destination source index; lane k at [k*IDXW +: IDXW].
- inMode  in  2: 00 pass, 01 shuffle, 10 broadcast, 11 reverse.
- inZeroMask  in  NLANES: bit k set forces output lane k to zero.
- outValid  out  1: output vector valid.
- outReady  in  1: consumer accepts output.
- outVec  out  NLANES*LANEW: permuted result.

Behaviour:
- Transfer rules: input transfer when inValid && inReady; output transfer when outValid && outReady.
- Stage S1 (capture register):
  - On input transfer, latches inVec, inMode and inZeroMask.
  - Resolves an effective index per lane:
    - pass: idx[k] = k.
    - shuffle: idx[k] = inIdx[k].
    - broadcast: idx[k] = inIdx[0] for all k.
    - reverse: idx[k] = NLANES-1-k.
  - S1 registers the resolved indices, not the raw inIdx.
- Stage S2 (output register):
  - outVec lane k = zeroMask[k] ? 0 : S1 lane[idx[k]].
  - outValid = S2 valid.
- Advance rules:
  - S2 loads when S1 is valid and (S2 empty or outReady).
  - S1 loads when inValid and (S1 empty or S1 advancing this cycle).
  - inReady = !S1valid || S1 advancing. Combinational, with no dependency on inValid.
- Latency and throughput:
  - Accepted vector appears on outValid exactly 2 clocks later if never stalled.
  - Throughput is one vector per clock.
- Stall:
  - While outValid && !outReady, outVec and outValid hold stable.
  - At most 2 vectors are in flight. With both stages full and outReady low, inReady = 0.
- Simultaneous events: output transfer and input transfer in the same cycle with both stages full is legal. S1 moves to S2 and the new input enters S1 with no bubble.
- Index boundary: indices are IDXW bits wide, so every value is in range and no wrap handling is needed. Duplicate indices are legal (fan-out).
- Reset values:
  - When reset is low at a clock edge: S1valid = 0, S2valid = 0, outValid = 0, outVec = 0. S1 data regs are cleared to 0.
  - inReady is 0 while reset is low and 1 on the first cycle after release.
  - Reset mid-operation discards in-flight vectors with no output transfer.
- Data regs do not toggle when their stage does not load.

Optional Feature:
- Macro: FPU_VEC_SHUF_NEGATE_EN.
- When defined:
  - Adds input port inNegMask [NLANES], latched with the input like inZeroMask.
  - Output lane k has its MSB (sign bit) inverted when negMask[k] = 1.
  - Negation is applied after the shuffle. Zero-mask takes precedence: a zeroed lane stays all-zero even if negated.
- When undefined: port absent, no sign manipulation, and no negate logic or registers are synthesised.

Decomposition:
- Shared package fpu_vec_pkg:
  - Mode encoding constants FPU_VSHUF_PASS = 2'b00, FPU_VSHUF_SHUF = 2'b01, FPU_VSHUF_BCAST = 2'b10, FPU_VSHUF_REV = 2'b11.
  - Typedef for the per-lane index vector.
- One sub-module, fpu_vec_lane_sel: purely combinational NLANES:1 selector for one output lane (index, lane array, zero bit -> lane). Instantiated NLANES times via generate in S2.

Test Plan:
- Pass mode (N=4, W=32):
  - Stimulus: inVec = {D,C,B,A} = {0x44444444, 0x33333333, 0x22222222, 0x11111111}, outReady = 1.
  - Required: outVec identical, outValid high exactly 2 cycles after accept.
- Shuffle mode:
  - Stimulus: inIdx lanes {k0=3, k1=3, k2=0, k3=1}, same inVec.
  - Required: outVec lanes = {0x44444444, 0x44444444, 0x11111111, 0x22222222}.
- Broadcast and reverse:
  - Broadcast with inIdx[0] = 2: all lanes 0x33333333.
  - Reverse: lane0 = 0x44444444 … lane3 = 0x11111111.
  - inZeroMask = 4'b0101 in both cases: lanes 0 and 2 = 0.
- Backpressure:
  - Stimulus: stream 6 vectors with outReady low for cycles 3–6.
  - Required: inReady drops when 2 vectors are in flight, outVec holds stable while stalled, all 6 emerge in order with no loss or duplication.
- Reset mid-stream:
  - Stimulus: assert reset low with 2 vectors in flight.
  - Required: next cycle outValid = 0, outVec = 0; no stale vector emerges after release.
- FPU_VEC_SHUF_NEGATE_EN:
  - Stimulus: inNegMask = 4'b0011, inZeroMask = 4'b0010, pass mode.
  - Required: lane0 = 0x91111111, lane1 = 0, lanes 2–3 unchanged.

Source files
------------

// File: rtl/fpu_vec_pkg.sv
// Shared definitions for the FPU vector shuffle path: mode encodings and index types.
package fpu_vec_pkg;

   localparam logic [1:0] FPU_VSHUF_PASS  = 2'b00;
   localparam logic [1:0] FPU_VSHUF_SHUF  = 2'b01;
   localparam logic [1:0] FPU_VSHUF_BCAST = 2'b10;
   localparam logic [1:0] FPU_VSHUF_REV   = 2'b11;

   // Sized for the largest supported lane count (16); narrower builds use the low bits.
   localparam int FPU_VSHUF_MAX_LANES = 16;
   localparam int FPU_VSHUF_MAX_IDXW  = 4;

   typedef logic [1:0]                           fpuVshufMode_t;
   typedef logic [FPU_VSHUF_MAX_IDXW-1:0]        fpuVshufIdx_t;
   typedef fpuVshufIdx_t [FPU_VSHUF_MAX_LANES-1:0] fpuVshufIdxVec_t;

endpackage

// File: rtl/fpu_vec_lane_sel.sv
// Combinational NLANES:1 lane selector for one output lane; a set zero bit forces the lane to 0.
module fpu_vec_lane_sel #(
   parameter int  NLANES = 4,
   parameter int  LANEW  = 32,
   localparam int IDXW   = $clog2(NLANES)
) (
   input  logic [IDXW-1:0]         idx,
   input  logic [NLANES*LANEW-1:0] lanes,
   input  logic                    zero,
   output logic [LANEW-1:0]        lane
);

   always_comb begin
      lane = '0;
      if (!zero) begin
         for (int j = 0; j < NLANES; j++) begin
            if (idx == IDXW'(j)) lane = lanes[j*LANEW +: LANEW];
         end
      end
   end

endmodule

// File: rtl/fpu_vec_shuf_pipe.sv
// Two-stage lane shuffle unit (pass / shuffle / broadcast / reverse, per-lane zero mask).
// Per-lane sign negation is added when FPU_VEC_SHUF_NEGATE_EN is defined.
module fpu_vec_shuf_pipe
   import fpu_vec_pkg::*;
#(
   parameter int  NLANES = 4,
   parameter int  LANEW  = 32,
   localparam int IDXW   = $clog2(NLANES)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    inValid,
   output logic                    inReady,
   input  logic [NLANES*LANEW-1:0] inVec,
   input  logic [NLANES*IDXW-1:0]  inIdx,
   input  logic [1:0]              inMode,
   input  logic [NLANES-1:0]       inZeroMask,
`ifdef FPU_VEC_SHUF_NEGATE_EN
   input  logic [NLANES-1:0]       inNegMask,
`endif
   output logic                    outValid,
   input  logic                    outReady,
   output logic [NLANES*LANEW-1:0] outVec
);

   // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits
   // on ready, and inReady looks only at pipeline occupancy and outReady, never at inValid.

   logic                          s1Valid, s2Valid;
   logic [NLANES*LANEW-1:0]       s1Vec, s2Vec;
   logic [NLANES-1:0][IDXW-1:0]   s1Idx, resIdx;
   logic [NLANES-1:0]             s1Zero;
   logic [NLANES-1:0][LANEW-1:0]  selLane, nxtVec;
   logic                          s1Load, s2Load;
`ifdef FPU_VEC_SHUF_NEGATE_EN
   logic [NLANES-1:0]             s1Neg;
`endif

   assign s2Load  = s1Valid && (!s2Valid || outReady);
   assign inReady = reset && (!s1Valid || s2Load);
   assign s1Load  = inValid && inReady;

   // The mode is folded into per-lane indices here, so S2 only ever does an indexed select.
   always_comb begin
      resIdx = '0;
      for (int k = 0; k < NLANES; k++) begin
         case (fpuVshufMode_t'(inMode))
            FPU_VSHUF_PASS:  resIdx[k] = IDXW'(k);
            FPU_VSHUF_SHUF:  resIdx[k] = inIdx[k*IDXW +: IDXW];
            FPU_VSHUF_BCAST: resIdx[k] = inIdx[IDXW-1:0];
            default:         resIdx[k] = IDXW'(NLANES - 1 - k);
         endcase
      end
   end

   for (genvar k = 0; k < NLANES; k++) begin : g_lane
      fpu_vec_lane_sel #(
         .NLANES (NLANES),
         .LANEW  (LANEW)
      ) u_sel (
         .idx   (s1Idx[k]),
         .lanes (s1Vec),
         .zero  (s1Zero[k]),
         .lane  (selLane[k])
      );
`ifdef FPU_VEC_SHUF_NEGATE_EN
      // Zeroed lanes must stay all-zero, so the sign flip is gated off for them.
      assign nxtVec[k] = (s1Neg[k] && !s1Zero[k])
                       ? {~selLane[k][LANEW-1], selLane[k][LANEW-2:0]}
                       : selLane[k];
`else
      assign nxtVec[k] = selLane[k];
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1Valid <= 1'b0;
         s2Valid <= 1'b0;
         s1Vec   <= '0;
         s1Idx   <= '0;
         s1Zero  <= '0;
         s2Vec   <= '0;
`ifdef FPU_VEC_SHUF_NEGATE_EN
         s1Neg   <= '0;
`endif
      end else begin
         if (s1Load) begin
            s1Vec  <= inVec;
            s1Idx  <= resIdx;
            s1Zero <= inZeroMask;
`ifdef FPU_VEC_SHUF_NEGATE_EN
            s1Neg  <= inNegMask;
`endif
         end
         if (s2Load) s2Vec <= nxtVec;
         s1Valid <= s1Load || (s1Valid && !s2Load);
         s2Valid <= s2Load || (s2Valid && !outReady);
      end
   end

   assign outValid = s2Valid;
   assign outVec   = s2Vec;

endmodule

// File: tb/tb_fpu_vec_shuf_pipe.sv
// Scoreboard bench for fpu_vec_shuf_pipe (N=4, W=32); covers FPU_VEC_SHUF_NEGATE_EN when defined.
module tb_fpu_vec_shuf_pipe;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int IW = 2;

   logic           clock = 1'b0;
   logic           reset;
   logic           inValid;
   logic           inReady;
   logic [N*W-1:0] inVec;
   logic [N*IW-1:0] inIdx;
   logic [1:0]     inMode;
   logic [N-1:0]   inZeroMask;
   logic [N-1:0]   inNegMask;
   logic           outValid;
   logic           outReady;
   logic [N*W-1:0] outVec;

   logic [N*W-1:0] exp_q[$];
   int             tests = 0;
   int             failed = 0;
   logic           stallPrev = 1'b0;
   logic [N*W-1:0] heldVec = '0;
   logic           rndDone;

   localparam logic [N*W-1:0] VEC_DCBA = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

   fpu_vec_shuf_pipe #(.NLANES(N), .LANEW(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .inValid    (inValid),
      .inReady    (inReady),
      .inVec      (inVec),
      .inIdx      (inIdx),
      .inMode     (inMode),
      .inZeroMask (inZeroMask),
`ifdef FPU_VEC_SHUF_NEGATE_EN
      .inNegMask  (inNegMask),
`endif
      .outValid   (outValid),
      .outReady   (outReady),
      .outVec     (outVec)
   );

   // clock / reset block
   always #5 clock = ~clock;

   function automatic void check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endfunction

   // Reference model: unpack lanes, pick a source lane from the mode rules, then apply masks.
   function automatic logic [N*W-1:0] model(input logic [N*W-1:0] v, input logic [N*IW-1:0] ix,
                                            input logic [1:0] m, input logic [N-1:0] zm,
                                            input logic [N-1:0] nm);
      logic [W-1:0]   src[N];
      logic [W-1:0]   lane;
      logic [N*W-1:0] res;
      int             s;
      for (int k = 0; k < N; k++) src[k] = v[k*W +: W];
      res = '0;
      for (int k = 0; k < N; k++) begin
         case (m)
            2'b00:   s = k;
            2'b01:   s = int'(ix[k*IW +: IW]);
            2'b10:   s = int'(ix[IW-1:0]);
            default: s = N - 1 - k;
         endcase
         lane = src[s];
`ifdef FPU_VEC_SHUF_NEGATE_EN
         if (nm[k]) lane[W-1] = ~lane[W-1];
`endif
         if (zm[k]) lane = '0;
         res[k*W +: W] = lane;
      end
      return res;
   endfunction

   // driver: present one vector, push its expected result on acceptance
   task automatic send(input logic [N*W-1:0] v, input logic [N*IW-1:0] ix, input logic [1:0] m,
                       input logic [N-1:0] zm, input logic [N-1:0] nm, input logic [N*W-1:0] e);
      inVec = v; inIdx = ix; inMode = m; inZeroMask = zm; inNegMask = nm;
      inValid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clock);
         if (inReady) begin
            exp_q.push_back(e);
            @(posedge clock); #1;
            inValid = 1'b0;
            return;
         end
         @(posedge clock); #1;
      end
      tests++; failed++;
      $display("FAIL send_timeout: inReady low for 200 cycles");
      inValid = 1'b0;
   endtask

   task automatic sendRandom();
      logic [N*W-1:0]  v;
      logic [N*IW-1:0] ix;
      logic [1:0]      m;
      logic [N-1:0]    zm, nm;
      for (int k = 0; k < N; k++) v[k*W +: W] = $urandom;
      ix = N*IW'($urandom);
      m  = 2'($urandom_range(0, 3));
      zm = N'($urandom_range(0, 15));
`ifdef FPU_VEC_SHUF_NEGATE_EN
      nm = N'($urandom_range(0, 15));
`else
      nm = '0;
`endif
      send(v, ix, m, zm, nm, model(v, ix, m, zm, nm));
   endtask

   task automatic drain();
      for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clock);
      #1;
      check("drain_empty", N*W'(exp_q.size()), '0);
   endtask

   // scoreboard monitor: pop and compare on every output transfer, check stall stability
   initial begin
      forever begin
         @(negedge clock);
         if (!reset) begin
            stallPrev = 1'b0;
         end else begin
            if (stallPrev) begin
               check("stall_valid", N*W'(outValid), N*W'(1));
               check("stall_hold", outVec, heldVec);
            end
            if (outValid && outReady) begin
               if (exp_q.size() == 0) begin
                  tests++; failed++;
                  $display("FAIL unexpected_output: got %h expected none", outVec);
               end else begin
                  check("out_vec", outVec, exp_q.pop_front());
               end
            end
            stallPrev = outValid && !outReady;
            heldVec   = outVec;
         end
      end
   end

   initial begin
      reset = 1'b0; inValid = 1'b0; inVec = '0; inIdx = '0; inMode = '0;
      inZeroMask = '0; inNegMask = '0; outReady = 1'b1; rndDone = 1'b0;

      // reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_out_valid", N*W'(outValid), '0);
      check("rst_out_vec", outVec, '0);
      check("rst_in_ready", N*W'(inReady), '0);
      @(posedge clock); #1; reset = 1'b1;
      @(negedge clock);
      check("rel_in_ready", N*W'(inReady), N*W'(1));
      @(posedge clock); #1;

      // pass mode with exact latency
      send(VEC_DCBA, '0, 2'b00, 4'b0000, 4'b0000, VEC_DCBA);
      @(negedge clock);
      check("lat_cycle1", N*W'(outValid), '0);
      @(negedge clock);
      check("lat_cycle2", N*W'(outValid), N*W'(1));
      @(posedge clock); #1;
      drain();

      // shuffle: k0=3 k1=3 k2=0 k3=1
      send(VEC_DCBA, {2'd1, 2'd0, 2'd3, 2'd3}, 2'b01, 4'b0000, 4'b0000,
           {32'h22222222, 32'h11111111, 32'h44444444, 32'h44444444});
      // broadcast idx0=2, zero lanes 0 and 2
      send(VEC_DCBA, {2'd0, 2'd0, 2'd0, 2'd2}, 2'b10, 4'b0101, 4'b0000,
           {32'h33333333, 32'h0, 32'h33333333, 32'h0});
      // reverse, zero lanes 0 and 2
      send(VEC_DCBA, '0, 2'b11, 4'b0101, 4'b0000,
           {32'h11111111, 32'h0, 32'h33333333, 32'h0});
`ifdef FPU_VEC_SHUF_NEGATE_EN
      send(VEC_DCBA, '0, 2'b00, 4'b0010, 4'b0011,
           {32'h44444444, 32'h33333333, 32'h0, 32'h91111111});
`endif
      drain();

      // two in flight with output blocked: input must stall
      outReady = 1'b0;
      send(VEC_DCBA, '0, 2'b00, 4'b0000, 4'b0000, VEC_DCBA);
      send(VEC_DCBA, '0, 2'b11, 4'b0000, 4'b0000, model(VEC_DCBA, '0, 2'b11, '0, '0));
      @(negedge clock);
      check("full_in_ready", N*W'(inReady), '0);
      check("full_out_valid", N*W'(outValid), N*W'(1));
      @(posedge clock); #1;
      outReady = 1'b1;
      drain();

      // stream 6 with outReady low for cycles 3..6
      fork
         begin
            for (int i = 0; i < 6; i++) sendRandom();
         end
         begin
            repeat (3) @(posedge clock);
            #1 outReady = 1'b0;
            repeat (4) @(posedge clock);
            #1 outReady = 1'b1;
         end
      join
      drain();

      // reset with two vectors in flight
      outReady = 1'b0;
      sendRandom();
      sendRandom();
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      exp_q.delete();
      @(negedge clock);
      check("midrst_out_valid", N*W'(outValid), '0);
      check("midrst_out_vec", outVec, '0);
      @(posedge clock); #1;
      reset = 1'b1; outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("post_rst_no_out", N*W'(outValid), '0);
      end
      @(posedge clock); #1;

      // randomized traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               sendRandom();
               repeat ($urandom_range(0, 1)) begin @(posedge clock); #1; end
            end
            rndDone = 1'b1;
         end
         begin
            while (!rndDone) begin
               @(posedge clock); #1;
               outReady = ($urandom_range(0, 3) != 0);
            end
         end
      join
      outReady = 1'b1;
      drain();

      // final report
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
